// File: rtl/test_harness_ctrl.sv
// test_harness_ctrl: run control for the pipelined RISC-V core (reset sequencing, cycle/instret counters, tohost result decode).
// Latency: cpu_rst_n rises RST_CYCLES clocks after rst falls; done/pass/timeout/fail_code register one cycle after the hit or expiry.
// Backpressure: none; snoops the store bus and retire strobe passively and never stalls the core.
//
// Ports:
//   clk, rst           - system clock, asynchronous active-high reset
//   mem_wr_en/addr/wdata - data-memory store port snooped for the tohost write
//   retire             - one instruction retired this cycle
//   cpu_rst_n          - active-low reset to CPU_Top
//   done/pass/timeout  - sticky result flags; fail_code = mem_wdata[31:1] of a failing write
//   cycle_cnt/instret_cnt - saturating RUN-cycle and retired-instruction counters
//
// Optional feature: define HARNESS_FREEZE_ON_DONE_EN to pull cpu_rst_n low again on
// entry to any terminal state, so the core stays quiescent for a memory dump.

module test_harness_ctrl #(
    parameter int unsigned RST_CYCLES     = 2,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        retire,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [30:0] fail_code,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam logic [7:0]  HOLD_LAST    = 8'(RST_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    logic tohost_hit;

    // Byte offset within the tohost word is don't-care: any store into that word counts.
    assign tohost_hit = mem_wr_en && (mem_addr[31:2] == TOHOST_ADDR[31:2]);

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^mem_addr[1:0];

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cpu_rst_n_d = cpu_rst_n_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        fail_code_d = fail_code_q;
        cycle_d     = cycle_q;
        instret_d   = instret_q;

        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    cpu_rst_n_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end

            ST_RUN: begin
                // Counters also step on the cycle that leaves RUN, so the final
                // values include the terminating cycle.
                if (cycle_q != CNT_MAX) begin
                    cycle_d = cycle_q + 32'd1;
                end
                if (retire && (instret_q != CNT_MAX)) begin
                    instret_d = instret_q + 32'd1;
                end

                // Priority: a decodable tohost write beats a simultaneous watchdog expiry.
                // Even values are not results and leave the watchdog armed.
                if (tohost_hit && (mem_wdata == 32'd1)) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (tohost_hit && mem_wdata[0]) begin
                    state_d     = ST_FAIL;
                    done_d      = 1'b1;
                    fail_code_d = mem_wdata[31:1];
                end else if (cycle_q == TIMEOUT_LAST) begin
                    state_d   = ST_TIMEOUT;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end

`ifdef HARNESS_FREEZE_ON_DONE_EN
                if (state_d != ST_RUN) begin
                    cpu_rst_n_d = 1'b0;
                end
`endif
            end

            // Terminal states hold everything until rst.
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            hold_q      <= 8'd0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= 31'd0;
            cycle_q     <= 32'd0;
            instret_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
        end
    end

    assign cpu_rst_n   = cpu_rst_n_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_code   = fail_code_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule
